axi_lite_apb_bridge: RTL and testbench
======================================

Name: axi_lite_apb_bridge

Overview:
Single-outstanding AXI4-Lite slave to APB master bridge. It sits directly upstream of the SPI APB peripheral and the other APB slaves, and converts CPU/LSU AXI4-Lite reads and writes into APB setup/access transfers. A watchdog aborts transfers that never see pready, such as a stalled XIP flash read.

Parameters:
ADDR_W, 32, address width on both sides
TIMEOUT_CYCLES, 4096, access-phase cycles before abort; 0 disables the watchdog
TO_W, 16, watchdog counter width; TIMEOUT_CYCLES must be < 2^TO_W

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
in_awvalid  in  1  write address valid
in_awready  out  1  write address accept
in_awaddr  in  ADDR_W  write address
in_awprot  in  3  write protection
in_wvalid  in  1  write data valid
in_wready  out  1  write data accept
in_wdata  in  32  write data
in_wstrb  in  4  byte strobes
in_bvalid  out  1  write response valid
in_bready  in  1  write response accept
in_bresp  out  2  00 OKAY, 10 SLVERR
in_arvalid  in  1  read address valid
in_arready  out  1  read address accept
in_araddr  in  ADDR_W  read address
in_arprot  in  3  read protection
in_rvalid  out  1  read data valid
in_rready  in  1  read data accept
in_rdata  out  32  read data
in_rresp  out  2  00 OKAY, 10 SLVERR
out_paddr  out  ADDR_W  APB address
out_psel  out  1  APB select
out_penable  out  1  APB enable
out_pprot  out  3  APB protection
out_pwrite  out  1  APB direction
out_pwdata  out  32  APB write data
out_pstrb  out  4  APB strobes; 0 on reads
out_pready  in  1  APB ready
out_prdata  in  32  APB read data
out_pslverr  in  1  APB error

Behaviour:
- Reset: all valid/ready/psel/penable/pwrite outputs 0; out_paddr, out_pwdata, out_pstrb, out_pprot, in_rdata 0; bresp/rresp 00; aw/w holding regs empty; last_grant = write; state IDLE.
- AW and W are accepted independently into one-entry holding regs. awready = IDLE and AW reg empty; wready = IDLE and W reg empty. arready = IDLE and no granted write this cycle.
- A write is ready when both holding regs are full; a read is ready when arvalid is high.
- IDLE -> SETUP when a read or write is ready. If both are ready, the type not served last wins (alternating). The granted read AR handshake occurs in that same cycle.
- SETUP: psel=1, penable=0; paddr, pprot, pwrite, pwdata and pstrb are registered and stay stable until the transfer ends. Always one cycle, then -> ACCESS.
- ACCESS: psel=1, penable=1. The watchdog counts from 0.
  - On pready: capture prdata and pslverr (resp = pslverr ? 10 : 00). Drop psel and penable next cycle. -> RESP_R or RESP_B.
  - No pready and count == TIMEOUT_CYCLES-1 (TIMEOUT_CYCLES != 0): abort. Drop psel and penable, set resp 10, set rdata 0. -> RESP.
- RESP_R: rvalid=1 held until rready; rdata/rresp stable. -> IDLE.
- RESP_B: bvalid=1 held until bready. Clear the AW/W regs. -> IDLE.
- Minimum latency, arvalid to rvalid: 3 cycles with zero-wait pready (IDLE, SETUP, ACCESS).
- Back-to-back: at least one IDLE cycle between APB transfers. psel is never high for two transfers without a gap.
- Reset mid-transfer: psel drops and no response is issued.
- Timeout abort leaves the slave mid-operation. The downstream slave must restart on its next psel.

Test Plan:
- Read 0x1000_1000, slave pready after 0 waits with prdata=0xDEADBEEF -> psel 1 cycle then penable 1 cycle; rvalid on cycle 3 with rdata 0xDEADBEEF, rresp 00.
- Write 0x1000_1014 with data 0x1 and wstrb 0xF, W presented 2 cycles after AW -> one APB write with pstrb F and pwdata 0x1; bresp 00 after the pready cycle.
- Read and write both valid at IDLE, repeated twice -> grant order read, write, read, write; no overlapping psel.
- Read 0x3000_0000, slave holds pready low, TIMEOUT_CYCLES=8 -> penable high exactly 8 cycles, then rvalid with rresp 10 and rdata 0.
- pslverr=1 on a write with bready held low 5 cycles -> bvalid stays 1 with bresp 10 throughout; awready stays 0 until the handshake.
- reset asserted during ACCESS -> next cycle psel=0, penable=0, rvalid=0, bvalid=0; the next read completes normally.

Source files
------------

// File: rtl/axi_lite_apb_bridge.sv
// axi_lite_apb_bridge
//   AXI4-Lite slave to APB master bridge with a single transfer outstanding.
//   Write address and write data are parked in one-entry holding registers
//   until both are present. Reads are granted directly from the AR channel.
//   When a read and a write are ready together, the type not served last wins.
//   A watchdog aborts an access phase that never sees pready, and the aborted
//   transfer is answered with SLVERR.
//
// Ports
//   clock, reset            system clock, synchronous active-high reset
//   in_aw* / in_w* / in_b*  AXI4-Lite write address, write data, write response
//   in_ar* / in_r*          AXI4-Lite read address, read data
//   out_p*                  APB master (paddr/psel/penable/pprot/pwrite/pwdata/pstrb
//                           out; pready/prdata/pslverr in)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | accept AW/W into holding regs, arbitrate and grant one transfer
// S_SETUP  | APB setup phase (psel=1, penable=0), always one cycle
// S_ACCESS | APB access phase (psel=1, penable=1), watchdog running
// S_RESP_R | rvalid held until rready
// S_RESP_B | bvalid held until bready, then the holding regs are released

`default_nettype none

module axi_lite_apb_bridge #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TO_W           = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_awvalid,
  output logic              in_awready,
  input  logic [ADDR_W-1:0] in_awaddr,
  input  logic [2:0]        in_awprot,
  input  logic              in_wvalid,
  output logic              in_wready,
  input  logic [31:0]       in_wdata,
  input  logic [3:0]        in_wstrb,
  output logic              in_bvalid,
  input  logic              in_bready,
  output logic [1:0]        in_bresp,
  input  logic              in_arvalid,
  output logic              in_arready,
  input  logic [ADDR_W-1:0] in_araddr,
  input  logic [2:0]        in_arprot,
  output logic              in_rvalid,
  input  logic              in_rready,
  output logic [31:0]       in_rdata,
  output logic [1:0]        in_rresp,
  output logic [ADDR_W-1:0] out_paddr,
  output logic              out_psel,
  output logic              out_penable,
  output logic [2:0]        out_pprot,
  output logic              out_pwrite,
  output logic [31:0]       out_pwdata,
  output logic [3:0]        out_pstrb,
  input  logic              out_pready,
  input  logic [31:0]       out_prdata,
  input  logic              out_pslverr
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_ACCESS = 3'd2,
    S_RESP_R = 3'd3,
    S_RESP_B = 3'd4
  } state_t;

  // Watchdog is a down-counter loaded on SETUP; reaching zero without pready
  // marks the last allowed access cycle.
  localparam logic        TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam int unsigned TO_LOAD_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TO_LOAD_I);

  state_t r_state;
  state_t w_state_nxt;

  logic              r_aw_full;
  logic [ADDR_W-1:0] r_aw_addr;
  logic [2:0]        r_aw_prot;
  logic              r_w_full;
  logic [31:0]       r_w_data;
  logic [3:0]        r_w_strb;
  logic              r_last_wr;
  logic [ADDR_W-1:0] r_paddr;
  logic [2:0]        r_pprot;
  logic              r_pwrite;
  logic [31:0]       r_pwdata;
  logic [3:0]        r_pstrb;
  logic [31:0]       r_rdata;
  logic [1:0]        r_resp;
  logic [TO_W-1:0]   r_wd_cnt;

  logic w_idle;
  logic w_wr_rdy;
  logic w_rd_rdy;
  logic w_grant_wr;
  logic w_grant_rd;
  logic w_done;
  logic w_abort;

  assign w_idle   = (r_state == S_IDLE);
  assign w_wr_rdy = r_aw_full & r_w_full;
  assign w_rd_rdy = in_arvalid;
  // On a tie the write wins only if the previous grant was a read.
  assign w_grant_wr = w_idle & w_wr_rdy & (~w_rd_rdy | ~r_last_wr);
  assign w_grant_rd = w_idle & w_rd_rdy & ~w_grant_wr;
  assign w_done     = (r_state == S_ACCESS) & out_pready;
  assign w_abort    = (r_state == S_ACCESS) & ~out_pready & TO_EN & (r_wd_cnt == '0);

  assign out_paddr  = r_paddr;
  assign out_pprot  = r_pprot;
  assign out_pwrite = r_pwrite;
  assign out_pwdata = r_pwdata;
  assign out_pstrb  = r_pstrb;
  assign in_rdata   = r_rdata;
  assign in_rresp   = r_resp;
  assign in_bresp   = r_resp;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_grant_wr || w_grant_rd) w_state_nxt = S_SETUP;
      S_SETUP:  w_state_nxt = S_ACCESS;
      S_ACCESS: if (w_done || w_abort) w_state_nxt = r_pwrite ? S_RESP_B : S_RESP_R;
      S_RESP_R: if (in_rready) w_state_nxt = S_IDLE;
      S_RESP_B: if (in_bready) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Ready outputs are forced low while reset is asserted.
  always_comb begin
    in_awready  = 1'b0;
    in_wready   = 1'b0;
    in_arready  = 1'b0;
    in_bvalid   = 1'b0;
    in_rvalid   = 1'b0;
    out_psel    = 1'b0;
    out_penable = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_awready = ~r_aw_full & ~reset;
        in_wready  = ~r_w_full & ~reset;
        in_arready = ~w_grant_wr & ~reset;
      end
      S_SETUP:  out_psel = 1'b1;
      S_ACCESS: begin
        out_psel    = 1'b1;
        out_penable = 1'b1;
      end
      S_RESP_R: in_rvalid = 1'b1;
      S_RESP_B: in_bvalid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_aw_full <= 1'b0;
      r_aw_addr <= '0;
      r_aw_prot <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_last_wr <= 1'b1;
      r_paddr   <= '0;
      r_pprot   <= '0;
      r_pwrite  <= 1'b0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_rdata   <= '0;
      r_resp    <= 2'b00;
      r_wd_cnt  <= '0;
    end else begin
      if (in_awvalid && in_awready) begin
        r_aw_full <= 1'b1;
        r_aw_addr <= in_awaddr;
        r_aw_prot <= in_awprot;
      end
      if (in_wvalid && in_wready) begin
        r_w_full <= 1'b1;
        r_w_data <= in_wdata;
        r_w_strb <= in_wstrb;
      end
      // Holding regs stay full through the transfer so AW/W stay blocked.
      if (r_state == S_RESP_B && in_bready) begin
        r_aw_full <= 1'b0;
        r_w_full  <= 1'b0;
      end

      if (w_grant_wr) begin
        r_paddr   <= r_aw_addr;
        r_pprot   <= r_aw_prot;
        r_pwrite  <= 1'b1;
        r_pwdata  <= r_w_data;
        r_pstrb   <= r_w_strb;
        r_last_wr <= 1'b1;
      end else if (w_grant_rd) begin
        r_paddr   <= in_araddr;
        r_pprot   <= in_arprot;
        r_pwrite  <= 1'b0;
        r_pwdata  <= '0;
        r_pstrb   <= '0;
        r_last_wr <= 1'b0;
      end

      if (r_state == S_SETUP)
        r_wd_cnt <= TO_LOAD;
      else if (r_state == S_ACCESS && r_wd_cnt != '0)
        r_wd_cnt <= r_wd_cnt - TO_W'(1);

      if (w_done) begin
        r_resp <= out_pslverr ? 2'b10 : 2'b00;
        if (!r_pwrite) r_rdata <= out_prdata;
      end else if (w_abort) begin
        r_resp  <= 2'b10;
        r_rdata <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_axi_lite_apb_bridge.sv
// tb_axi_lite_apb_bridge
//   Directed scenarios followed by randomized single transactions. The bench
//   owns an APB slave model (configurable wait count, data and error) and
//   derives every expected response from the bridge's transaction rules.

`timescale 1ns/1ps

module tb_axi_lite_apb_bridge;

  localparam int TO    = 8;
  localparam int NEVER = 1000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_awvalid = 1'b0;
  logic        in_awready;
  logic [31:0] in_awaddr = '0;
  logic [2:0]  in_awprot = '0;
  logic        in_wvalid = 1'b0;
  logic        in_wready;
  logic [31:0] in_wdata = '0;
  logic [3:0]  in_wstrb = '0;
  logic        in_bvalid;
  logic        in_bready = 1'b0;
  logic [1:0]  in_bresp;
  logic        in_arvalid = 1'b0;
  logic        in_arready;
  logic [31:0] in_araddr = '0;
  logic [2:0]  in_arprot = '0;
  logic        in_rvalid;
  logic        in_rready = 1'b0;
  logic [31:0] in_rdata;
  logic [1:0]  in_rresp;
  logic [31:0] out_paddr;
  logic        out_psel;
  logic        out_penable;
  logic [2:0]  out_pprot;
  logic        out_pwrite;
  logic [31:0] out_pwdata;
  logic [3:0]  out_pstrb;
  logic        out_pready = 1'b0;
  logic [31:0] out_prdata;
  logic        out_pslverr;

  axi_lite_apb_bridge #(
    .ADDR_W(32), .TIMEOUT_CYCLES(TO), .TO_W(16)
  ) u_dut (
    .clock(clock), .reset(reset),
    .in_awvalid(in_awvalid), .in_awready(in_awready), .in_awaddr(in_awaddr), .in_awprot(in_awprot),
    .in_wvalid(in_wvalid), .in_wready(in_wready), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
    .in_bvalid(in_bvalid), .in_bready(in_bready), .in_bresp(in_bresp),
    .in_arvalid(in_arvalid), .in_arready(in_arready), .in_araddr(in_araddr), .in_arprot(in_arprot),
    .in_rvalid(in_rvalid), .in_rready(in_rready), .in_rdata(in_rdata), .in_rresp(in_rresp),
    .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable), .out_pprot(out_pprot),
    .out_pwrite(out_pwrite), .out_pwdata(out_pwdata), .out_pstrb(out_pstrb),
    .out_pready(out_pready), .out_prdata(out_prdata), .out_pslverr(out_pslverr)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // APB slave model: pready after slv_wait access cycles (NEVER = stall).
  int          slv_wait = 0;
  int          slv_cnt  = 0;
  logic [31:0] slv_data = '0;
  logic        slv_err  = 1'b0;
  assign out_prdata  = slv_data;
  assign out_pslverr = slv_err;

  always @(negedge clock) begin
    if (out_psel && out_penable) begin
      out_pready = (slv_cnt == slv_wait);
      slv_cnt++;
    end else begin
      out_pready = 1'b0;
      slv_cnt = 0;
    end
  end

  // APB monitor: one record per psel burst, with access-cycle count.
  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          en;
  } apb_t;

  apb_t mon_q[$];
  apb_t cur;
  logic prev_psel = 1'b0;

  always @(negedge clock) begin
    if (out_psel && !out_penable) begin
      chk("apb_gap", prev_psel, 1'b0);
      cur.wr    = out_pwrite;
      cur.addr  = out_paddr;
      cur.wdata = out_pwdata;
      cur.strb  = out_pstrb;
      cur.prot  = out_pprot;
      cur.en    = 0;
    end else if (out_psel && out_penable) begin
      cur.en++;
      chk("apb_stable", {out_pwrite, out_pprot, out_pstrb, out_paddr},
          {cur.wr, cur.prot, cur.strb, cur.addr});
      chk("apb_wdata_stable", out_pwdata, cur.wdata);
    end
    if (prev_psel && !out_psel) mon_q.push_back(cur);
    prev_psel = out_psel;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic send_ar(input logic [31:0] a, input logic [2:0] p, output int waited);
    waited = 0;
    in_arvalid = 1'b1; in_araddr = a; in_arprot = p;
    #1;
    while (!in_arready && waited < 200) begin @(negedge clock); #1; waited++; end
    chk("ar_handshake", in_arready, 1'b1);
    @(negedge clock);
    in_arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [2:0] p, input int dly);
    int waited = 0;
    repeat (dly) @(negedge clock);
    in_awvalid = 1'b1; in_awaddr = a; in_awprot = p;
    #1;
    while (!in_awready && waited < 200) begin @(negedge clock); #1; waited++; end
    chk("aw_handshake", in_awready, 1'b1);
    @(negedge clock);
    in_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    int waited = 0;
    repeat (dly) @(negedge clock);
    in_wvalid = 1'b1; in_wdata = d; in_wstrb = s;
    #1;
    while (!in_wready && waited < 200) begin @(negedge clock); #1; waited++; end
    chk("w_handshake", in_wready, 1'b1);
    @(negedge clock);
    in_wvalid = 1'b0;
  endtask

  function automatic int exp_en_cycles(input int w);
    return (w + 1 < TO) ? w + 1 : TO;
  endfunction

  task automatic do_read(input logic [31:0] a, input logic [2:0] p, input int w,
                         input logic [31:0] sd, input logic se, input int hold);
    int waited, cyc, en;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    apb_t rec;
    slv_wait = w; slv_data = sd; slv_err = se;
    en       = exp_en_cycles(w);
    exp_resp = (w >= TO || se) ? 2'b10 : 2'b00;
    exp_data = (w >= TO) ? 32'h0 : sd;
    send_ar(a, p, waited);
    cyc = 1;
    while (!in_rvalid && cyc < 300) begin @(negedge clock); cyc++; end
    chk("r_valid", in_rvalid, 1'b1);
    if (waited == 0) chk("r_latency", cyc, 2 + en);
    chk("r_data", in_rdata, exp_data);
    chk("r_resp", in_rresp, exp_resp);
    repeat (hold) begin
      @(negedge clock);
      chk("r_hold", {in_rvalid, in_rresp, in_rdata}, {1'b1, exp_resp, exp_data});
    end
    in_rready = 1'b1;
    @(negedge clock);
    in_rready = 1'b0;
    chk("r_drop", in_rvalid, 1'b0);
    chk("r_apb_count", mon_q.size(), 1);
    if (mon_q.size() > 0) begin
      rec = mon_q.pop_front();
      chk("r_apb_fields", {rec.wr, rec.prot, rec.strb, rec.addr}, {1'b0, p, 4'h0, a});
      chk("r_apb_en", rec.en, en);
    end
  endtask

  // skew > 0 delays W after AW, skew < 0 delays AW after W.
  task automatic do_write(input logic [31:0] a, input logic [2:0] p, input logic [31:0] d,
                          input logic [3:0] s, input int skew, input int w,
                          input logic se, input int hold);
    int cyc, en;
    logic [1:0] exp_resp;
    apb_t rec;
    slv_wait = w; slv_data = $urandom; slv_err = se;
    en       = exp_en_cycles(w);
    exp_resp = (w >= TO || se) ? 2'b10 : 2'b00;
    fork
      send_aw(a, p, (skew < 0) ? -skew : 0);
      send_w(d, s, (skew > 0) ? skew : 0);
    join
    cyc = 1;
    while (!in_bvalid && cyc < 300) begin @(negedge clock); cyc++; end
    chk("b_valid", in_bvalid, 1'b1);
    chk("b_latency", cyc, 3 + en);
    chk("b_resp", in_bresp, exp_resp);
    repeat (hold) begin
      @(negedge clock);
      chk("b_hold", {in_bvalid, in_bresp, in_awready, in_wready}, {1'b1, exp_resp, 1'b0, 1'b0});
    end
    in_bready = 1'b1;
    @(negedge clock);
    in_bready = 1'b0;
    chk("b_drop", in_bvalid, 1'b0);
    chk("b_aw_free", {in_awready, in_wready}, 2'b11);
    chk("w_apb_count", mon_q.size(), 1);
    if (mon_q.size() > 0) begin
      rec = mon_q.pop_front();
      chk("w_apb_fields", {rec.wr, rec.prot, rec.strb, rec.addr}, {1'b1, p, s, a});
      chk("w_apb_wdata", rec.wdata, d);
      chk("w_apb_en", rec.en, en);
    end
  endtask

  // Read and write contend twice: expected grant order R1, W1, R2, W2.
  task automatic arb_test();
    logic [32:0] exp_arb [4];
    exp_arb = '{{1'b0, 32'h1000_0100}, {1'b1, 32'h1000_0200},
                {1'b0, 32'h1000_0104}, {1'b1, 32'h1000_0204}};
    slv_wait = 0; slv_err = 1'b0; slv_data = 32'h0BAD_F00D;
    in_rready = 1'b1; in_bready = 1'b1;
    fork
      begin
        int wt;
        send_ar(32'h1000_0100, 3'd0, wt);
        send_ar(32'h1000_0104, 3'd0, wt);
      end
      begin
        int c;
        fork
          send_aw(32'h1000_0200, 3'd1, 0);
          send_w(32'h1111_2222, 4'hF, 0);
        join
        c = 0;
        while (!in_bvalid && c < 200) begin @(negedge clock); c++; end
        chk("arb_b1", in_bvalid, 1'b1);
        @(negedge clock);
        fork
          send_aw(32'h1000_0204, 3'd1, 0);
          send_w(32'h3333_4444, 4'h3, 0);
        join
        c = 0;
        while (!in_bvalid && c < 200) begin @(negedge clock); c++; end
        chk("arb_b2", in_bvalid, 1'b1);
        @(negedge clock);
      end
    join
    repeat (2) @(negedge clock);
    in_rready = 1'b0; in_bready = 1'b0;
    chk("arb_count", mon_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < mon_q.size()) chk("arb_order", {mon_q[i].wr, mon_q[i].addr}, exp_arb[i]);
    mon_q.delete();
  endtask

  task automatic reset_mid_test();
    int wt, c;
    slv_wait = NEVER; slv_err = 1'b0;
    send_ar(32'h2000_0040, 3'd2, wt);
    c = 0;
    while (!out_penable && c < 50) begin @(negedge clock); c++; end
    chk("rstmid_in_access", out_penable, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rstmid_outputs", {out_psel, out_penable, in_rvalid, in_bvalid}, 4'b0000);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("rstmid_no_resp", {in_rvalid, in_bvalid}, 2'b00);
    mon_q.delete();
    do_read(32'h2000_0044, 3'd0, 1, 32'hCAFE_0001, 1'b0, 0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    chk("rst_ctrl", {in_awready, in_wready, in_arready, in_bvalid, in_rvalid,
                     out_psel, out_penable, out_pwrite}, 8'h00);
    chk("rst_paddr", out_paddr, 32'h0);
    chk("rst_data", {out_pwdata, in_rdata}, 64'h0);
    chk("rst_misc", {out_pstrb, out_pprot, in_bresp, in_rresp}, 11'h0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_ready", {in_awready, in_wready, in_arready}, 3'b111);

    do_read(32'h1000_1000, 3'd0, 0, 32'hDEAD_BEEF, 1'b0, 0);
    do_write(32'h1000_1014, 3'd0, 32'h0000_0001, 4'hF, 2, 0, 1'b0, 0);
    arb_test();
    do_read(32'h3000_0000, 3'd0, NEVER, 32'h5A5A_5A5A, 1'b0, 1);
    do_write(32'h1000_2000, 3'd3, 32'hA5A5_0F0F, 4'h5, -1, 1, 1'b1, 5);
    reset_mid_test();

    for (int i = 0; i < 40; i++) begin
      int          sel, w, skew, hold;
      logic [31:0] a, d;
      sel = $urandom_range(0, 9);
      if (sel < 6)      w = $urandom_range(0, 3);
      else if (sel < 8) w = $urandom_range(5, 9);
      else              w = NEVER;
      a    = $urandom & 32'hFFFF_FFFC;
      d    = $urandom;
      skew = $urandom_range(0, 4) - 2;
      hold = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 0)
        do_read(a, 3'($urandom_range(0, 7)), w, d, 1'($urandom_range(0, 3) == 0), hold);
      else
        do_write(a, 3'($urandom_range(0, 7)), d, 4'($urandom_range(0, 15)), skew, w,
                 1'($urandom_range(0, 3) == 0), hold);
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
